// File: rtl/tx_header_appender.sv
// RDMA transmit header appender: prefixes each payload segment with a BTH
// beat and a length/PSN beat, and owns the 24-bit transmit PSN counter.
module tx_header_appender #(
   parameter int DATA_W = 64,
   parameter int META_W = 64
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic [META_W-1:0] iMETA,
   input  logic              iMETA_VALID,
   output logic              oMETA_READY,
   input  logic [DATA_W-1:0] iTDATA,
   input  logic              iTVALID,
   input  logic              iTLAST,
   output logic              oTREADY,
   output logic [DATA_W-1:0] oTDATA,
   output logic              oTVALID,
   output logic              oTLAST,
   input  logic              iTREADY,
   input  logic              iPSN_LOAD,
   input  logic [23:0]       iPSN_VALUE,
   output logic [23:0]       oPSN,
   output logic              oBUSY,
   output logic              oERR
);

   typedef enum logic [1:0] {
      IDLE,
      HDR0,
      HDR1,
      PAYLOAD
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [7:0]  opcode;
   logic [23:0] dest_qp;
   logic [15:0] length;
   logic        ack_req;
   logic [23:0] hdr_psn;
   logic [23:0] psn;
   logic [13:0] beat_cnt;
   logic        err;

   logic        len_zero;
   logic        pay_xfer;
   logic [16:0] exp_beats;
   logic [16:0] got_beats;
   logic        unused_meta;

   assign unused_meta = ^iMETA[META_W-1:49];

   assign len_zero  = (length == 16'd0);
   assign pay_xfer  = (state == PAYLOAD) && iTVALID && iTREADY;
   // 17 bits so that length 16'hFFFF does not wrap when rounding up
   assign exp_beats = ({1'b0, length} + 17'd7) >> 3;
   assign got_beats = {3'b000, beat_cnt} + 17'd1;

   assign oPSN = psn;
   assign oERR = err;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      oMETA_READY = 1'b0;
      oTVALID     = 1'b0;
      oTLAST      = 1'b0;
      oTREADY     = 1'b0;
      oTDATA      = '0;
      oBUSY       = 1'b1;
      unique case (state)
         IDLE: begin
            oBUSY       = 1'b0;
            oMETA_READY = 1'b1;
            if (iMETA_VALID) begin
               state_nxt = HDR0;
            end
         end
         HDR0: begin
            oTVALID = 1'b1;
            oTDATA  = {opcode, 8'h00, 16'hFFFF, 8'h00, dest_qp};
            if (iTREADY) begin
               state_nxt = HDR1;
            end
         end
         HDR1: begin
            oTVALID = 1'b1;
            oTLAST  = len_zero;
            oTDATA  = {ack_req, 7'b0, hdr_psn, length, 16'h0000};
            if (iTREADY) begin
               state_nxt = len_zero ? IDLE : PAYLOAD;
            end
         end
         PAYLOAD: begin
            oTDATA  = iTDATA;
            oTVALID = iTVALID;
            oTLAST  = iTLAST;
            oTREADY = iTREADY;
            if (pay_xfer && iTLAST) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         opcode   <= '0;
         dest_qp  <= '0;
         length   <= '0;
         ack_req  <= 1'b0;
         hdr_psn  <= '0;
         psn      <= '0;
         beat_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (iPSN_LOAD) begin
               psn <= iPSN_VALUE;
            end
            // a coincident load is what the accepted packet carries
            if (iMETA_VALID) begin
               opcode   <= iMETA[7:0];
               dest_qp  <= iMETA[31:8];
               length   <= iMETA[47:32];
               ack_req  <= iMETA[48];
               hdr_psn  <= iPSN_LOAD ? iPSN_VALUE : psn;
               beat_cnt <= '0;
            end
         end
         if ((state == HDR1) && iTREADY) begin
            psn <= psn + 24'd1;
         end
         if (pay_xfer) begin
            beat_cnt <= beat_cnt + 14'd1;
            if (iTLAST && (got_beats != exp_beats)) begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tx_header_appender.sv
// Self-checking bench for tx_header_appender against a packet-level
// reference model (header fields, PSN sequence, beat-count error).
module tb_tx_header_appender;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   logic [63:0] iMETA = '0;
   logic        iMETA_VALID = 1'b0;
   logic        oMETA_READY;
   logic [63:0] iTDATA = '0;
   logic        iTVALID = 1'b0;
   logic        iTLAST = 1'b0;
   logic        oTREADY;
   logic [63:0] oTDATA;
   logic        oTVALID;
   logic        oTLAST;
   logic        iTREADY = 1'b1;
   logic        iPSN_LOAD = 1'b0;
   logic [23:0] iPSN_VALUE = '0;
   logic [23:0] oPSN;
   logic        oBUSY;
   logic        oERR;

   always #5 iClk = ~iClk;

   tx_header_appender #(.DATA_W(64), .META_W(64)) dut (
      .iClk(iClk), .iRst(iRst),
      .iMETA(iMETA), .iMETA_VALID(iMETA_VALID), .oMETA_READY(oMETA_READY),
      .iTDATA(iTDATA), .iTVALID(iTVALID), .iTLAST(iTLAST), .oTREADY(oTREADY),
      .oTDATA(oTDATA), .oTVALID(oTVALID), .oTLAST(oTLAST), .iTREADY(iTREADY),
      .iPSN_LOAD(iPSN_LOAD), .iPSN_VALUE(iPSN_VALUE), .oPSN(oPSN),
      .oBUSY(oBUSY), .oERR(oERR)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [64:0] obs[$];
   int          obs_cyc[$];
   logic [64:0] exp_q[$];

   int          m_psn;
   bit          m_err;
   int          acc_cyc;
   int          rdy_pct = 100;
   bit          stab_on = 0;
   bit          tready_seen = 0;
   bit          held = 0;
   logic [63:0] held_data;
   logic        held_last;

   always @(posedge iClk) cyc <= cyc + 1;

   // transfer monitor: a beat seen valid&&ready here moves on the next edge
   always @(negedge iClk) begin
      if (!iRst) begin
         if (oTREADY) tready_seen = 1;
         if (stab_on && held) begin
            total++;
            if (oTVALID !== 1'b1 || oTDATA !== held_data || oTLAST !== held_last) begin
               bad++;
               $display("FAIL stall_stable: got v=%b d=%h l=%b need v=1 d=%h l=%b",
                        oTVALID, oTDATA, oTLAST, held_data, held_last);
            end
         end
         held      = oTVALID && !iTREADY;
         held_data = oTDATA;
         held_last = oTLAST;
         if (oTVALID && iTREADY) begin
            obs.push_back({oTLAST, oTDATA});
            obs_cyc.push_back(cyc + 1);
         end
      end else begin
         held = 0;
      end
   end

   function automatic logic [63:0] mk_meta(input logic [7:0] op, input logic [23:0] qp,
                                           input logic [15:0] len, input logic ack);
      logic [14:0] rsv;
      rsv = 15'($urandom);
      return {rsv, ack, len, qp, op};
   endfunction

   task automatic do_reset();
      iRst = 1;
      iMETA_VALID = 0; iTVALID = 0; iTLAST = 0; iPSN_LOAD = 0;
      iTREADY = 1; rdy_pct = 100; stab_on = 0;
      repeat (2) @(negedge iClk);
      iRst = 0;
      obs.delete(); obs_cyc.delete(); exp_q.delete();
      m_psn = 0; m_err = 0; tready_seen = 0;
      @(posedge iClk); #1;
   endtask

   task automatic send_pkt(input logic [63:0] meta, input int nb,
                           input bit ld, input logic [23:0] ldv);
      logic [63:0] pay[$];
      int          ln;
      int          target;
      int          t;
      bit          tmo;
      ln = int'(meta[47:32]);
      for (int i = 0; i < nb; i++) pay.push_back({$urandom, $urandom});
      if (ld) m_psn = int'(ldv);
      exp_q.push_back({1'b0, meta[7:0], 8'h00, 16'hFFFF, 8'h00, meta[31:8]});
      exp_q.push_back({ln == 0, meta[48], 7'b0, m_psn[23:0], meta[47:32], 16'h0000});
      m_psn = (m_psn + 1) % (1 << 24);
      if (ln != 0) begin
         for (int i = 0; i < nb; i++) exp_q.push_back({i == nb - 1, pay[i]});
         if (nb != (ln + 7) / 8) m_err = 1;
      end
      target = exp_q.size();
      tmo = 0;
      iTREADY = (rdy_pct >= 100);
      fork
         begin
            iMETA = meta; iMETA_VALID = 1; iPSN_LOAD = ld; iPSN_VALUE = ldv;
            t = 0;
            while (t < 200) begin
               @(negedge iClk); t++;
               if (oMETA_READY) begin
                  acc_cyc = cyc + 1;
                  @(posedge iClk); #1;
                  break;
               end
            end
            iMETA_VALID = 0; iPSN_LOAD = 0;
            for (int i = 0; i < nb && t < 30000; i++) begin
               if (rdy_pct < 100 && $urandom_range(2) == 0) begin
                  iTVALID = 0;
                  @(posedge iClk); #1;
               end
               iTVALID = 1; iTDATA = pay[i]; iTLAST = (i == nb - 1);
               while (t < 30000) begin
                  @(negedge iClk); t++;
                  if (oTREADY) break;
               end
               @(posedge iClk); #1;
            end
            iTVALID = 0; iTLAST = 0;
         end
         begin
            int c = 0;
            while (obs.size() < target && c < 30000) begin
               @(posedge iClk); #1;
               iTREADY = ($urandom_range(99) < rdy_pct);
               c++;
            end
            if (obs.size() < target) tmo = 1;
         end
      join
      iTREADY = 1;
      total++;
      if (tmo) begin
         bad++;
         $display("FAIL pkt_timeout: got %0d beats need %0d", obs.size(), target);
      end
   endtask

   task automatic test_reset();
      iRst = 0;
      #2 iRst = 1;
      #1;
      total += 7;
      if (oTVALID !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b need 0", oTVALID); end
      if (oTLAST !== 1'b0) begin bad++; $display("FAIL rst_tlast: got %b need 0", oTLAST); end
      if (oTREADY !== 1'b0) begin bad++; $display("FAIL rst_tready: got %b need 0", oTREADY); end
      if (oMETA_READY !== 1'b1) begin bad++; $display("FAIL rst_meta_ready: got %b need 1", oMETA_READY); end
      if (oBUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b need 0", oBUSY); end
      if (oERR !== 1'b0) begin bad++; $display("FAIL rst_err: got %b need 0", oERR); end
      if (oPSN !== 24'd0) begin bad++; $display("FAIL rst_psn: got %h need 0", oPSN); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      send_pkt(mk_meta(8'h04, 24'h000123, 16'd20, 1'b0), 3, 0, '0);
      total++;
      if (obs.size() != 5) begin bad++; $display("FAIL single_count: got %0d need 5", obs.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (((i < obs.size()) ? obs[i] : 65'bx) !== exp_q[i]) begin
            bad++; $display("FAIL single_beat%0d: got %h need %h", i, (i < obs.size()) ? obs[i] : 65'bx, exp_q[i]);
         end
         total++;
         if (((i < obs_cyc.size()) ? obs_cyc[i] : -1) != acc_cyc + 1 + i) begin
            bad++; $display("FAIL single_lat%0d: got cyc %0d need %0d", i, (i < obs_cyc.size()) ? obs_cyc[i] : -1, acc_cyc + 1 + i);
         end
      end
      if (obs.size() >= 5) begin
         total += 3;
         if (obs[0][63:0] !== 64'h0400FFFF00000123) begin bad++; $display("FAIL single_bth: got %h need 0400ffff00000123", obs[0][63:0]); end
         if (obs[1][63:0] !== 64'h0000000000140000) begin bad++; $display("FAIL single_lenword: got %h need 0000000000140000", obs[1][63:0]); end
         if (obs[4][64] !== 1'b1) begin bad++; $display("FAIL single_last: got %b need 1", obs[4][64]); end
      end
      total += 2;
      if (oPSN !== 24'd1) begin bad++; $display("FAIL single_psn: got %h need 1", oPSN); end
      if (oERR !== 1'b0) begin bad++; $display("FAIL single_err: got %b need 0", oERR); end
   endtask

   task automatic test_zero_len();
      do_reset();
      iTVALID = 1; iTDATA = 64'hDEAD_BEEF_0BAD_F00D; iTLAST = 1;
      send_pkt(mk_meta(8'h11, 24'hABCDEF, 16'd0, 1'b1), 0, 0, '0);
      repeat (3) @(posedge iClk);
      #1;
      total++;
      if (obs.size() != 2) begin bad++; $display("FAIL zero_count: got %0d need 2", obs.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (((i < obs.size()) ? obs[i] : 65'bx) !== exp_q[i]) begin
            bad++; $display("FAIL zero_beat%0d: got %h need %h", i, (i < obs.size()) ? obs[i] : 65'bx, exp_q[i]);
         end
      end
      if (obs.size() >= 2) begin
         total++;
         if (obs[1] !== {1'b1, 64'h8000000000000000}) begin bad++; $display("FAIL zero_hdr1: got %h need 1_8000000000000000", obs[1]); end
      end
      total += 2;
      if (tready_seen) begin bad++; $display("FAIL zero_tready: got 1 need 0"); end
      if (oPSN !== 24'd1) begin bad++; $display("FAIL zero_psn: got %h need 1", oPSN); end
      iTVALID = 0; iTLAST = 0;
   endtask

   task automatic test_psn_wrap();
      do_reset();
      send_pkt(mk_meta(8'h0A, 24'h000777, 16'd8, 1'b0), 1, 1, 24'hFFFFFF);
      total++;
      if (oPSN !== 24'd0) begin bad++; $display("FAIL wrap_psn: got %h need 0", oPSN); end
      send_pkt(mk_meta(8'h0B, 24'h000778, 16'd5, 1'b1), 1, 0, '0);
      total++;
      if (oPSN !== 24'd1) begin bad++; $display("FAIL wrap_psn2: got %h need 1", oPSN); end
      if (obs.size() >= 5) begin
         total += 2;
         if (obs[1][55:32] !== 24'hFFFFFF) begin bad++; $display("FAIL wrap_hdr_psn: got %h need ffffff", obs[1][55:32]); end
         if (obs[4][55:32] !== 24'h000000) begin bad++; $display("FAIL wrap_next_psn: got %h need 0", obs[4][55:32]); end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (((i < obs.size()) ? obs[i] : 65'bx) !== exp_q[i]) begin
            bad++; $display("FAIL wrap_beat%0d: got %h need %h", i, (i < obs.size()) ? obs[i] : 65'bx, exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int ln;
      do_reset();
      rdy_pct = 50;
      stab_on = 1;
      for (int k = 0; k < 8; k++) begin
         ln = (k == 3) ? 0 : $urandom_range(1, 48);
         send_pkt(mk_meta(8'($urandom), 24'($urandom), 16'(ln), 1'($urandom)), (ln + 7) / 8, 0, '0);
      end
      stab_on = 0;
      rdy_pct = 100;
      total++;
      if (obs.size() != exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d need %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (((i < obs.size()) ? obs[i] : 65'bx) !== exp_q[i]) begin
            bad++; $display("FAIL bp_beat%0d: got %h need %h", i, (i < obs.size()) ? obs[i] : 65'bx, exp_q[i]);
         end
      end
      total += 2;
      if (oPSN !== 24'(m_psn)) begin bad++; $display("FAIL bp_psn: got %h need %h", oPSN, m_psn); end
      if (oERR !== m_err) begin bad++; $display("FAIL bp_err: got %b need %b", oERR, m_err); end
   endtask

   task automatic test_len_boundary();
      int lens[6] = '{1, 8, 9, 16, 17, 65535};
      do_reset();
      foreach (lens[j]) begin
         send_pkt(mk_meta(8'h2A, 24'h000100 + 24'(j), 16'(lens[j]), 1'b0), (lens[j] + 7) / 8, 0, '0);
      end
      total++;
      if (obs.size() != exp_q.size()) begin bad++; $display("FAIL bnd_count: got %0d need %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (((i < obs.size()) ? obs[i] : 65'bx) !== exp_q[i]) begin
            bad++; $display("FAIL bnd_beat%0d: got %h need %h", i, (i < obs.size()) ? obs[i] : 65'bx, exp_q[i]);
         end
      end
      total += 2;
      if (oERR !== 1'b0) begin bad++; $display("FAIL bnd_err: got %b need 0", oERR); end
      if (oPSN !== 24'd6) begin bad++; $display("FAIL bnd_psn: got %h need 6", oPSN); end
   endtask

   task automatic test_mismatch();
      do_reset();
      send_pkt(mk_meta(8'h04, 24'h000123, 16'd20, 1'b0), 2, 0, '0);
      total += 2;
      if (obs.size() != 4) begin bad++; $display("FAIL mis_count: got %0d need 4", obs.size()); end
      if (oERR !== 1'b1) begin bad++; $display("FAIL mis_err: got %b need 1", oERR); end
      if (obs.size() >= 4) begin
         total++;
         if (obs[3][64] !== 1'b1) begin bad++; $display("FAIL mis_last: got %b need 1", obs[3][64]); end
      end
      send_pkt(mk_meta(8'h05, 24'h000124, 16'd16, 1'b0), 2, 0, '0);
      send_pkt(mk_meta(8'h06, 24'h000125, 16'd3, 1'b1), 1, 0, '0);
      total++;
      if (oERR !== 1'b1) begin bad++; $display("FAIL mis_sticky: got %b need 1", oERR); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (((i < obs.size()) ? obs[i] : 65'bx) !== exp_q[i]) begin
            bad++; $display("FAIL mis_beat%0d: got %h need %h", i, (i < obs.size()) ? obs[i] : 65'bx, exp_q[i]);
         end
      end
      do_reset();
      send_pkt(mk_meta(8'h07, 24'h000126, 16'd8, 1'b0), 3, 0, '0);
      total++;
      if (oERR !== 1'b1) begin bad++; $display("FAIL mis_long: got %b need 1", oERR); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_pkt(mk_meta(8'h0C, 24'h000200, 16'd16, 1'b0), 2, 0, '0);
      send_pkt(mk_meta(8'h0D, 24'h000201, 16'd8, 1'b0), 1, 0, '0);
      total++;
      if (obs_cyc.size() != 7) begin bad++; $display("FAIL b2b_count: got %0d need 7", obs_cyc.size()); end
      if (obs_cyc.size() >= 7) begin
         total += 3;
         if (obs_cyc[4] - obs_cyc[3] != 2) begin bad++; $display("FAIL b2b_gap: got %0d need 2", obs_cyc[4] - obs_cyc[3]); end
         if (obs_cyc[3] - obs_cyc[0] != 3) begin bad++; $display("FAIL b2b_burst1: got %0d need 3", obs_cyc[3] - obs_cyc[0]); end
         if (obs_cyc[6] - obs_cyc[4] != 2) begin bad++; $display("FAIL b2b_burst2: got %0d need 2", obs_cyc[6] - obs_cyc[4]); end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (((i < obs.size()) ? obs[i] : 65'bx) !== exp_q[i]) begin
            bad++; $display("FAIL b2b_beat%0d: got %h need %h", i, (i < obs.size()) ? obs[i] : 65'bx, exp_q[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      iMETA = mk_meta(8'h0E, 24'h000300, 16'd32, 1'b0);
      iMETA_VALID = 1;
      iTREADY = 1;
      @(posedge iClk); #1;
      iMETA_VALID = 0;
      iTVALID = 1; iTDATA = {$urandom, $urandom}; iTLAST = 0;
      repeat (3) @(posedge iClk);
      #2;
      total += 3;
      if (oTREADY !== 1'b1) begin bad++; $display("FAIL ar_in_payload: got %b need 1", oTREADY); end
      if (oBUSY !== 1'b1) begin bad++; $display("FAIL ar_busy_pre: got %b need 1", oBUSY); end
      if (oPSN !== 24'd1) begin bad++; $display("FAIL ar_psn_pre: got %h need 1", oPSN); end
      iRst = 1;
      #1;
      total += 4;
      if (oTVALID !== 1'b0) begin bad++; $display("FAIL ar_tvalid: got %b need 0", oTVALID); end
      if (oBUSY !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b need 0", oBUSY); end
      if (oPSN !== 24'd0) begin bad++; $display("FAIL ar_psn: got %h need 0", oPSN); end
      if (oTREADY !== 1'b0) begin bad++; $display("FAIL ar_tready: got %b need 0", oTREADY); end
      iTVALID = 0;
      #3 iRst = 0;
      obs.delete(); obs_cyc.delete(); exp_q.delete();
      m_psn = 0; m_err = 0;
      @(posedge iClk); #1;
      send_pkt(mk_meta(8'h0F, 24'h000301, 16'd16, 1'b1), 2, 0, '0);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (((i < obs.size()) ? obs[i] : 65'bx) !== exp_q[i]) begin
            bad++; $display("FAIL ar_beat%0d: got %h need %h", i, (i < obs.size()) ? obs[i] : 65'bx, exp_q[i]);
         end
      end
      total++;
      if (oPSN !== 24'd1) begin bad++; $display("FAIL ar_psn_after: got %h need 1", oPSN); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_len();
      test_psn_wrap();
      test_backpressure();
      test_len_boundary();
      test_mismatch();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish need finish by 900000");
      $fatal(1, "watchdog");
   end

endmodule
